// File: rtl/alu_pkg.sv
`default_nettype none
// alu_pkg: shared op/cond encodings, NZCV bit indices and issuer states (rev 1.0)
package alu_pkg;
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam logic [1:0] OP_OR   = 2'b11;

    localparam logic [1:0] COND_AL = 2'b00;
    localparam logic [1:0] COND_EQ = 2'b01;
    localparam logic [1:0] COND_NE = 2'b10;
    localparam logic [1:0] COND_CS = 2'b11;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;
endpackage
`default_nettype wire

// File: rtl/alu_cmd_issuer_if.sv
`default_nettype none
// alu_cmd_issuer_if: command, ALU and response signals of the issuer (rev 1.0)
interface alu_cmd_issuer_if #(
    parameter int WIDTH = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic [1:0]       cmd_cond;
    logic             cmd_setf;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [1:0]       alu_ctrl;
    logic [WIDTH-1:0] alu_result;
    logic             alu_v;
    logic             alu_c;
    logic             alu_n;
    logic             alu_z;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic [3:0]       rsp_flags;
    logic             rsp_skipped;

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_cond, cmd_setf,
        output cmd_ready,
        output alu_a, alu_b, alu_ctrl,
        input  alu_result, alu_v, alu_c, alu_n, alu_z,
        output rsp_valid, rsp_result, rsp_flags, rsp_skipped,
        input  rsp_ready
    );

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_cond, cmd_setf,
        input  cmd_ready,
        input  alu_a, alu_b, alu_ctrl,
        output alu_result, alu_v, alu_c, alu_n, alu_z,
        input  rsp_valid, rsp_result, rsp_flags, rsp_skipped,
        output rsp_ready
    );
endinterface
`default_nettype wire

// File: rtl/alu_cond_check.sv
`default_nettype none
// alu_cond_check: evaluates a command condition against the NZCV register (rev 1.0)
module alu_cond_check
    import alu_pkg::*;
(
    input  logic [1:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);
    // N and V are not consulted by any supported condition
    logic unused_flags;
    assign unused_flags = nzcv[FLAG_N] ^ nzcv[FLAG_V];

    always_comb begin
        pass = 1'b1;
        case (cond)
            COND_AL: pass = 1'b1;
            COND_EQ: pass = nzcv[FLAG_Z];
            COND_NE: pass = ~nzcv[FLAG_Z];
            COND_CS: pass = nzcv[FLAG_C];
            default: pass = 1'b1;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/alu_cmd_issuer.sv
`default_nettype none
// alu_cmd_issuer: registers commands, drives the external ALU, keeps NZCV and returns responses (rev 1.0)
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int         WIDTH     = 4,
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_cmd_issuer_if.slave bus
);
    state_t           state;
    logic             ready;
    logic             valid;
    logic [WIDTH-1:0] result;
    logic             skipped;
    logic [1:0]       cur_op;
    logic [WIDTH-1:0] cur_a;
    logic [WIDTH-1:0] cur_b;
    logic [1:0]       cur_cond;
    logic             cur_setf;
    logic [3:0]       nzcv;
    logic             cond_pass;

    alu_cond_check u_cond_check (
        .cond (cur_cond),
        .nzcv (nzcv),
        .pass (cond_pass)
    );

    assign bus.cmd_ready   = ready;
    assign bus.alu_a       = cur_a;
    assign bus.alu_b       = cur_b;
    assign bus.alu_ctrl    = cur_op;
    assign bus.rsp_valid   = valid;
    assign bus.rsp_result  = result;
    assign bus.rsp_flags   = nzcv;
    assign bus.rsp_skipped = skipped;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            ready    <= 1'b1;
            valid    <= 1'b0;
            result   <= '0;
            skipped  <= 1'b0;
            cur_op   <= OP_ADD;
            cur_a    <= '0;
            cur_b    <= '0;
            cur_cond <= COND_AL;
            cur_setf <= 1'b0;
            nzcv     <= FLAGS_RST;
        end else begin
            case (state)
                ST_IDLE: begin
                    ready <= 1'b1;
                    if (bus.cmd_valid && ready) begin
                        cur_op   <= bus.cmd_op;
                        cur_a    <= bus.cmd_a;
                        cur_b    <= bus.cmd_b;
                        cur_cond <= bus.cmd_cond;
                        cur_setf <= bus.cmd_setf;
                        ready    <= 1'b0;
                        state    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // ALU inputs have been stable since the accept edge
                    if (cond_pass) begin
                        result  <= bus.alu_result;
                        skipped <= 1'b0;
                        if (cur_setf) begin
                            nzcv <= {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v};
                        end
                    end else begin
                        result  <= '0;
                        skipped <= 1'b1;
                    end
                    valid <= 1'b1;
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        valid <= 1'b0;
                        ready <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    valid <= 1'b0;
                    ready <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire
